// File: rtl/tod_pkg.sv
// Shared types and constants for the time-of-day set controller.
// BCD layout of the 24-bit time bus: {h1,h0,m1,m0,s1,s0}.
package tod_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_e;

  localparam int DIG_W  = 4;
  localparam int FLD_W  = 2 * DIG_W;
  localparam int TIME_W = 6 * DIG_W;

  localparam int H_LSB = 4 * DIG_W;
  localparam int M_LSB = 2 * DIG_W;
  localparam int S_LSB = 0;

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MS_MAX   = 7'd59;

  localparam logic [5:0] MASK_H = 6'b110000;
  localparam logic [5:0] MASK_M = 6'b001100;
  localparam logic [5:0] MASK_S = 6'b000011;

  // Wrapping BCD increment of one two-digit field.
  // Anything out of range (bad digit or above max) restarts at 00.
  function automatic logic [FLD_W-1:0] bcd_inc(
    input logic [FLD_W-1:0] f,
    input logic [6:0]       max
  );
    logic [3:0] t;
    logic [3:0] o;
    logic [7:0] v;
    t = f[7:4];
    o = f[3:0];
    v = {4'd0, t} * 8'd10 + {4'd0, o};
    if (t > 4'd9 || o > 4'd9) begin
      bcd_inc = '0;
    end else if (v >= {1'b0, max}) begin
      bcd_inc = '0;
    end else if (o == 4'd9) begin
      bcd_inc = {t + 4'd1, 4'd0};
    end else begin
      bcd_inc = {t, o + 4'd1};
    end
  endfunction

endpackage

// File: rtl/tod_set_controller_if.sv
// Bus between the set controller, the time counter and the HEX decoders.
// master: controller side (drives tick/load/display); slave: counter/display side.
interface tod_set_controller_if;
  import tod_pkg::*;

  logic [TIME_W-1:0] cur_time;
  logic              tick_1hz;
  logic              load;
  logic [TIME_W-1:0] load_time;
  logic [TIME_W-1:0] disp_time;
  logic [5:0]        blank_mask;
  logic [1:0]        mode;

  modport master (
    input  cur_time,
    output tick_1hz,
    output load,
    output load_time,
    output disp_time,
    output blank_mask,
    output mode
  );

  modport slave (
    output cur_time,
    input  tick_1hz,
    input  load,
    input  load_time,
    input  disp_time,
    input  blank_mask,
    input  mode
  );

endinterface

// File: rtl/tod_set_controller_key.sv
// key_sync_edge: 2-FF synchronizer plus falling-edge detector for a raw key.
// Ports: clk, reset, key_n_i (raw active-low key), press_o (one pulse per press).
module key_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic press_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // Released level is 1, so flops come out of reset as "not pressed".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= key_n_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign press_o = prev_q & ~s2_q;

endmodule

// File: rtl/tod_set_controller.sv
// Time-of-day sequencer: 1 Hz count enable, key-driven set FSM, blink, load.
// Ports: clk, reset, key_mode_n, key_inc_n, bus (master: cur_time in; tick, load, display out).
module tod_set_controller
  import tod_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_mode_n,
  input  logic                         key_inc_n,
  tod_set_controller_if.master         bus
);

  localparam int PS_W = $clog2(CLK_HZ);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BK_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BK_W-1:0] BK_LAST = BK_W'(HALF - 1);

  logic mode_p;
  logic inc_p;

  key_sync_edge u_key_mode (
    .clk     (clk),
    .reset   (reset),
    .key_n_i (key_mode_n),
    .press_o (mode_p)
  );

  key_sync_edge u_key_inc (
    .clk     (clk),
    .reset   (reset),
    .key_n_i (key_inc_n),
    .press_o (inc_p)
  );

  mode_e state_q;
  mode_e state_d;

  logic [TIME_W-1:0] edit_q;
  logic [TIME_W-1:0] edit_d;
  logic [PS_W-1:0]   ps_q;
  logic [PS_W-1:0]   ps_d;
  logic [BK_W-1:0]   bk_q;
  logic [BK_W-1:0]   bk_d;
  logic              ph_q;
  logic              ph_d;
  logic              load_q;
  logic              load_d;
  logic [TIME_W-1:0] ltime_q;
  logic [TIME_W-1:0] ltime_d;

  logic              tick;
  logic [5:0]        blank;
  logic [TIME_W-1:0] disp;
  logic [FLD_W-1:0]  fld;
  logic [FLD_W-1:0]  fld_inc;
  logic [6:0]        fmax;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: mode key steps RUN -> H -> M -> S -> RUN
  always_comb begin
    state_d = state_q;
    if (mode_p) begin
      unique case (state_q)
        RUN:   state_d = SET_H;
        SET_H: state_d = SET_M;
        SET_M: state_d = SET_S;
        SET_S: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Outputs and next values of the datapath
  always_comb begin
    tick    = (state_q == RUN) && (ps_q == PS_LAST);
    load_d  = (state_q == SET_S) && mode_p;
    ltime_d = load_d ? edit_q : ltime_q;
    disp    = (state_q == RUN) ? bus.cur_time : edit_q;
    blank   = '0;
    if (ph_q) begin
      unique case (1'b1)
        (state_q == SET_H): blank = MASK_H;
        (state_q == SET_M): blank = MASK_M;
        (state_q == SET_S): blank = MASK_S;
        default:            blank = '0;
      endcase
    end
  end

  // Single incrementer, field and limit picked by the edit state
  always_comb begin
    fld  = edit_q[S_LSB +: FLD_W];
    fmax = MS_MAX;
    unique case (1'b1)
      (state_q == SET_H): begin
        fld  = edit_q[H_LSB +: FLD_W];
        fmax = HOUR_MAX;
      end
      (state_q == SET_M): fld = edit_q[M_LSB +: FLD_W];
      default: ;
    endcase
  end

  assign fld_inc = bcd_inc(fld, fmax);

  // Mode press has priority; a coincident inc is dropped
  always_comb begin
    edit_d = edit_q;
    if (state_q == RUN) begin
      if (mode_p) edit_d = bus.cur_time;
    end else if (inc_p && !mode_p) begin
      unique case (state_q)
        SET_H:   edit_d[H_LSB +: FLD_W] = fld_inc;
        SET_M:   edit_d[M_LSB +: FLD_W] = fld_inc;
        SET_S:   edit_d[S_LSB +: FLD_W] = fld_inc;
        default: ;
      endcase
    end
  end

  // Prescaler parks at 0 while editing so RUN restarts a full second
  always_comb begin
    if (state_q != RUN || tick) begin
      ps_d = '0;
    end else begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  // Blink timer is idle in RUN, so entry to SET_H starts it at phase 0
  always_comb begin
    bk_d = bk_q;
    ph_d = ph_q;
    if (state_q == RUN) begin
      bk_d = '0;
      ph_d = 1'b0;
    end else if (bk_q == BK_LAST) begin
      bk_d = '0;
      ph_d = ~ph_q;
    end else begin
      bk_d = bk_q + BK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edit_q  <= '0;
      ps_q    <= '0;
      bk_q    <= '0;
      ph_q    <= 1'b0;
      load_q  <= 1'b0;
      ltime_q <= '0;
    end else begin
      edit_q  <= edit_d;
      ps_q    <= ps_d;
      bk_q    <= bk_d;
      ph_q    <= ph_d;
      load_q  <= load_d;
      ltime_q <= ltime_d;
    end
  end

  assign bus.tick_1hz   = tick;
  assign bus.load       = load_q;
  assign bus.load_time  = ltime_q;
  assign bus.disp_time  = disp;
  assign bus.blank_mask = blank;
  assign bus.mode       = state_q;

endmodule

// File: tb/tb_tod_set_controller.sv
// Bench for tod_set_controller: directed key sequences with a scoreboard
// for load strobes and tick timing, plus direct display checks.
module tb_tod_set_controller;
  import tod_pkg::*;

  localparam int CLK_HZ   = 10;
  localparam int BLINK_HZ = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_mode_n = 1'b1;
  logic key_inc_n = 1'b1;

  tod_set_controller_if bus ();

  tod_set_controller #(
    .CLK_HZ   (CLK_HZ),
    .BLINK_HZ (BLINK_HZ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_mode_n (key_mode_n),
    .key_inc_n  (key_inc_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ec = 0;
  int mark = 0;

  logic [23:0] sb_load[$];
  int          sb_tick[$];
  logic [23:0] exp_l;
  int          exp_t;

  always @(posedge clk) ec <= ec + 1;

  // Monitor: pops expected loads/ticks as the DUT presents them
  always @(negedge clk) begin
    if (bus.load) begin
      total++;
      if (bus.tick_1hz) begin
        bad++;
        $display("FAIL load_tick_overlap: tick=1 want 0");
      end
      total++;
      if (sb_load.size() == 0) begin
        bad++;
        $display("FAIL unexpected_load: load_time=%h want no load",
                 bus.load_time);
      end else begin
        exp_l = sb_load.pop_front();
        if (bus.load_time !== exp_l) begin
          bad++;
          $display("FAIL load_time: got %h want %h", bus.load_time, exp_l);
        end
      end
      mark = ec;
    end else if (bus.tick_1hz) begin
      if (sb_tick.size() != 0) begin
        exp_t = sb_tick.pop_front();
        total++;
        if (ec - mark != exp_t) begin
          bad++;
          $display("FAIL tick_time: got offset %0d want %0d",
                   ec - mark, exp_t);
        end
      end else if (bus.mode != 2'd0) begin
        total++;
        bad++;
        $display("FAIL tick_in_set: mode=%0d tick=1 want 0", bus.mode);
      end
    end
  end

  task automatic chk(input string nm, input logic [23:0] act,
                     input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic press(input bit m, input bit i, input int hold);
    @(negedge clk);
    if (m) key_mode_n = 1'b0;
    if (i) key_inc_n = 1'b0;
    repeat (hold) @(negedge clk);
    key_mode_n = 1'b1;
    key_inc_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ticks(input int limit);
    int n;
    n = 0;
    while (sb_tick.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb_tick.size() != 0) begin
      bad++;
      $display("FAIL tick_timeout: pending=%0d want 0", sb_tick.size());
      sb_tick.delete();
    end
  endtask

  task automatic check_blink();
    logic [5:0] v[2];
    int n;
    int run;
    n = 0;
    v[0] = bus.blank_mask;
    while (bus.blank_mask == v[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("blink_edge_seen", 24'(n < 20), 24'd1);
    for (int k = 0; k < 4; k++) begin
      v[k % 2] = bus.blank_mask;
      run = 0;
      while (bus.blank_mask == v[k % 2] && run < 20) begin
        @(negedge clk);
        run++;
      end
      chk("blink_run_len", 24'(run), 24'd5);
      if (k % 2 == 1) begin
        chk("blink_alt", 24'(v[0] ^ v[1]), 24'h00000c);
        chk("blink_set", 24'(v[0] | v[1]), 24'h00000c);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    bus.cur_time = 24'h235958;
    repeat (3) @(negedge clk);
    chk("rst_mode", 24'(bus.mode), 24'd0);
    chk("rst_load", 24'(bus.load), 24'd0);
    chk("rst_tick", 24'(bus.tick_1hz), 24'd0);
    chk("rst_blank", 24'(bus.blank_mask), 24'd0);
    chk("rst_load_time", bus.load_time, 24'h000000);
    chk("rst_disp", bus.disp_time, 24'h235958);

    reset = 1'b0;
    mark = ec;
    sb_tick.push_back(9);
    sb_tick.push_back(19);
    sb_tick.push_back(29);
    wait_ticks(40);
    chk("run_mode", 24'(bus.mode), 24'd0);
    repeat (3) @(negedge clk);

    press(1'b1, 1'b0, 2);
    chk("seth_mode", 24'(bus.mode), 24'd1);
    chk("seth_disp", bus.disp_time, 24'h235958);
    repeat (25) @(negedge clk);
    press(1'b0, 1'b1, 2);
    chk("hour_wrap", bus.disp_time, 24'h005958);

    press(1'b1, 1'b0, 2);
    chk("setm_mode", 24'(bus.mode), 24'd2);
    press(1'b0, 1'b1, 2);
    chk("min_wrap", bus.disp_time, 24'h000058);
    press(1'b0, 1'b1, 2);
    chk("min_inc", bus.disp_time, 24'h000158);
    press(1'b1, 1'b0, 2);
    chk("sets_mode", 24'(bus.mode), 24'd3);
    press(1'b0, 1'b1, 2);
    chk("sec_inc", bus.disp_time, 24'h000159);
    sb_load.push_back(24'h000159);
    sb_tick.push_back(9);
    press(1'b1, 1'b0, 2);
    chk("back_run", 24'(bus.mode), 24'd0);
    chk("load_seen", 24'(sb_load.size()), 24'd0);
    wait_ticks(30);

    bus.cur_time = 24'h240965;
    press(1'b1, 1'b0, 2);
    chk("snap_disp", bus.disp_time, 24'h240965);
    press(1'b0, 1'b1, 2);
    chk("bad_hour", bus.disp_time, 24'h000965);
    press(1'b1, 1'b1, 2);
    chk("both_mode", 24'(bus.mode), 24'd2);
    chk("both_disp", bus.disp_time, 24'h000965);
    press(1'b0, 1'b1, 2);
    chk("min_carry", bus.disp_time, 24'h001065);
    check_blink();
    press(1'b0, 1'b1, 100);
    chk("hold_inc", bus.disp_time, 24'h001165);
    press(1'b1, 1'b0, 2);
    press(1'b0, 1'b1, 2);
    chk("bad_sec", bus.disp_time, 24'h001100);
    sb_load.push_back(24'h001100);
    press(1'b1, 1'b0, 2);
    chk("load2_seen", 24'(sb_load.size()), 24'd0);

    bus.cur_time = 24'h123456;
    press(1'b1, 1'b0, 2);
    press(1'b1, 1'b0, 2);
    press(1'b1, 1'b0, 2);
    chk("sets2_mode", 24'(bus.mode), 24'd3);
    press(1'b0, 1'b1, 2);
    chk("sets2_disp", bus.disp_time, 24'h123457);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_mode", 24'(bus.mode), 24'd0);
    chk("mid_rst_blank", 24'(bus.blank_mask), 24'd0);
    chk("mid_rst_disp", bus.disp_time, 24'h123456);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mark = ec;
    sb_tick.push_back(9);
    wait_ticks(30);
    chk("mid_rst_load_time", bus.load_time, 24'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
